snn_layer_scheduler: RTL and testbench

Synchronous controller that sequences one SNN convolution layer across timesteps. It issues memory read/write commands toward the memory-side packetizer, releases the three PEs once their operands are loaded, and collects adder results (membrane potential plus spike). It writes each result back to memory. It is the single point that decides what runs when in the memory → NoC → PE → adder → memory loop.

---
 rtl/snn_sched_pkg.sv | 41 ++++
 rtl/snn_sched_cmd_reg.sv | 59 +++++
 rtl/snn_layer_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_snn_layer_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// ============================================================================
// Module      : snn_sched_pkg
// Description : Shared types and constants for the SNN layer scheduler:
//               FSM state encoding, memory command opcodes, command field
//               width and watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_sched_pkg;

    // Width of the t/x/y fields on the memory command bus
    localparam int CMD_W = 8;

    // Memory command opcodes (2'b11 is reserved and never issued)
    localparam logic [1:0] OP_RD_FILT  = 2'b00;
    localparam logic [1:0] OP_RD_IFMAP = 2'b01;
    localparam logic [1:0] OP_WR_RES   = 2'b10;

    // Watchdog terminal count for the wait states
    localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILT     = 3'd1,
        ST_IFMAP    = 3'd2,
        ST_START    = 3'd3,
        ST_WAIT_PE  = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_WRITE    = 3'd6,
        ST_DONE     = 3'd7
    } sched_state_t;

    // Counter width for a loop bound; never below one bit
    function automatic int cnt_w(input int bound);
        return (bound <= 2) ? 1 : $clog2(bound);
    endfunction

endpackage

`default_nettype wire

// File: rtl/snn_sched_cmd_reg.sv
// ============================================================================
// Module      : snn_sched_cmd_reg
// Description : Valid/ready holding register for the memory command payload.
//               A load captures a new payload and raises valid; the payload
//               is frozen until a transfer. Load and transfer may coincide,
//               giving one command per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_sched_cmd_reg
    import snn_sched_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [1:0]        load_op,
    input  logic [CMD_W-1:0]  load_t,
    input  logic [CMD_W-1:0]  load_x,
    input  logic [CMD_W-1:0]  load_y,
    input  logic [DATA_W:0]   load_data,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [CMD_W-1:0]  cmd_t,
    output logic [CMD_W-1:0]  cmd_x,
    output logic [CMD_W-1:0]  cmd_y,
    output logic [DATA_W:0]   cmd_data,
    output logic              fire
);

    assign fire = cmd_valid & cmd_ready;

    // Hold the payload while valid; a load always wins over a plain transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_t     <= '0;
            cmd_x     <= '0;
            cmd_y     <= '0;
            cmd_data  <= '0;
        end else if (load) begin
            cmd_valid <= 1'b1;
            cmd_op    <= load_op;
            cmd_t     <= load_t;
            cmd_x     <= load_x;
            cmd_y     <= load_y;
            cmd_data  <= load_data;
        end else if (fire) begin
            cmd_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/snn_layer_scheduler.sv
// ============================================================================
// Module      : snn_layer_scheduler
// Description : Sequences one SNN convolution layer over NUM_T timesteps:
//               filter load, per-row ifmap load, PE release, result collection
//               and result write-back. Optional watchdog on the wait states is
//               enabled by defining SNN_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_layer_scheduler
    import snn_sched_pkg::*;
#(
    parameter int NUM_T       = 10,
    parameter int OUT_DIM     = 3,
    parameter int FILTER_SIZE = 5,
    parameter int PE_COUNT    = 3,
    parameter int DATA_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
`ifdef SNN_SCHED_TIMEOUT_EN
    output logic                error,
`endif
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [1:0]          cmd_op,
    output logic [CMD_W-1:0]    cmd_t,
    output logic [CMD_W-1:0]    cmd_x,
    output logic [CMD_W-1:0]    cmd_y,
    output logic [DATA_W:0]     cmd_data,
    output logic [PE_COUNT-1:0] pe_start,
    input  logic [PE_COUNT-1:0] pe_done,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [DATA_W-1:0]   res_membrane,
    input  logic                res_spike
);

    localparam int T_W  = cnt_w(NUM_T);
    localparam int RC_W = cnt_w(OUT_DIM);
    localparam int I_W  = cnt_w(FILTER_SIZE);

    localparam logic [T_W-1:0]  T_LAST  = T_W'(NUM_T - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(OUT_DIM - 1);
    localparam logic [I_W-1:0]  I_LAST  = I_W'(FILTER_SIZE - 1);

    sched_state_t          state;
    logic [T_W-1:0]        t_cnt;
    logic [RC_W-1:0]       r_cnt;
    logic [RC_W-1:0]       c_cnt;
    logic [I_W-1:0]        i_cnt;
    logic [PE_COUNT-1:0]   pe_mask;
    logic [PE_COUNT-1:0]   mask_next;

    logic                  fire;
    logic                  timeout;
    logic                  load;
    logic [1:0]            load_op;
    logic [CMD_W-1:0]      load_t;
    logic [CMD_W-1:0]      load_x;
    logic [CMD_W-1:0]      load_y;
    logic [DATA_W:0]       load_data;

    logic                  i_last;
    logic                  c_last;
    logic                  r_last;
    logic                  t_last;

    assign i_last    = (i_cnt == I_LAST);
    assign c_last    = (c_cnt == RC_LAST);
    assign r_last    = (r_cnt == RC_LAST);
    assign t_last    = (t_cnt == T_LAST);
    assign mask_next = pe_mask | pe_done;

`ifdef SNN_SCHED_TIMEOUT_EN
    logic [15:0] wdog;
    assign timeout = ((state == ST_WAIT_PE) || (state == ST_WAIT_RES)) && (wdog == WDOG_LIMIT);
`else
    assign timeout = 1'b0;
`endif

    snn_sched_cmd_reg #(
        .DATA_W    (DATA_W)
    ) u_cmd_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_op   (load_op),
        .load_t    (load_t),
        .load_x    (load_x),
        .load_y    (load_y),
        .load_data (load_data),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_t     (cmd_t),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_data  (cmd_data),
        .fire      (fire)
    );

    // Next command payload, loaded on the same edge the FSM advances so a
    // follow-on command is valid in the cycle right after a transfer
    always_comb begin
        load      = 1'b0;
        load_op   = OP_RD_FILT;
        load_t    = '0;
        load_x    = '0;
        load_y    = '0;
        load_data = '0;
        case (state)
            ST_IDLE: begin
                if (start) load = 1'b1;
            end
            ST_FILT: begin
                if (fire) begin
                    load = 1'b1;
                    if (i_last) begin
                        load_op = OP_RD_IFMAP;
                        load_t  = CMD_W'(t_cnt);
                        load_x  = CMD_W'(r_cnt);
                    end else begin
                        load_x  = CMD_W'(i_cnt) + CMD_W'(1);
                    end
                end
            end
            ST_IFMAP: begin
                if (fire && !i_last) begin
                    load    = 1'b1;
                    load_op = OP_RD_IFMAP;
                    load_t  = CMD_W'(t_cnt);
                    load_x  = CMD_W'(r_cnt) + CMD_W'(i_cnt) + CMD_W'(1);
                end
            end
            ST_WAIT_RES: begin
                if (res_valid && res_ready && !timeout) begin
                    load      = 1'b1;
                    load_op   = OP_WR_RES;
                    load_t    = CMD_W'(t_cnt);
                    load_x    = CMD_W'(r_cnt);
                    load_y    = CMD_W'(c_cnt);
                    load_data = {res_spike, res_membrane};
                end
            end
            ST_WRITE: begin
                if (fire && c_last) begin
                    if (!r_last) begin
                        load    = 1'b1;
                        load_op = OP_RD_IFMAP;
                        load_t  = CMD_W'(t_cnt);
                        load_x  = CMD_W'(r_cnt) + CMD_W'(1);
                    end else if (!t_last) begin
                        load    = 1'b1;
                        load_op = OP_RD_IFMAP;
                        load_t  = CMD_W'(t_cnt) + CMD_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Main sequencer: state, loop counters, PE done mask and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            t_cnt     <= '0;
            r_cnt     <= '0;
            c_cnt     <= '0;
            i_cnt     <= '0;
            pe_mask   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pe_start  <= '0;
            res_ready <= 1'b0;
`ifdef SNN_SCHED_TIMEOUT_EN
            error     <= 1'b0;
            wdog      <= '0;
`endif
        end else begin
            done     <= 1'b0;
            pe_start <= '0;
`ifdef SNN_SCHED_TIMEOUT_EN
            wdog     <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_FILT;
                        busy    <= 1'b1;
                        t_cnt   <= '0;
                        r_cnt   <= '0;
                        c_cnt   <= '0;
                        i_cnt   <= '0;
                        pe_mask <= '0;
`ifdef SNN_SCHED_TIMEOUT_EN
                        error   <= 1'b0;
`endif
                    end
                end
                ST_FILT: begin
                    if (fire) begin
                        if (i_last) begin
                            i_cnt <= '0;
                            state <= ST_IFMAP;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end
                end
                ST_IFMAP: begin
                    if (fire) begin
                        if (i_last) begin
                            i_cnt    <= '0;
                            state    <= ST_START;
                            pe_start <= '1;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    // Clearing and capturing in one step keeps a done pulse
                    // that lands in the release cycle
                    pe_mask <= pe_done;
                    state   <= ST_WAIT_PE;
                end
                ST_WAIT_PE: begin
                    if (timeout) begin
`ifdef SNN_SCHED_TIMEOUT_EN
                        error <= 1'b1;
`endif
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        pe_mask <= mask_next;
                        if (&mask_next) begin
                            state     <= ST_WAIT_RES;
                            res_ready <= 1'b1;
                        end else begin
`ifdef SNN_SCHED_TIMEOUT_EN
                            wdog <= wdog + 16'd1;
`endif
                        end
                    end
                end
                ST_WAIT_RES: begin
                    if (timeout) begin
`ifdef SNN_SCHED_TIMEOUT_EN
                        error <= 1'b1;
`endif
                        res_ready <= 1'b0;
                        state     <= ST_DONE;
                        done      <= 1'b1;
                    end else if (res_valid) begin
                        res_ready <= 1'b0;
                        state     <= ST_WRITE;
                    end else begin
`ifdef SNN_SCHED_TIMEOUT_EN
                        wdog <= wdog + 16'd1;
`endif
                    end
                end
                ST_WRITE: begin
                    if (fire) begin
                        if (!c_last) begin
                            c_cnt     <= c_cnt + 1'b1;
                            state     <= ST_WAIT_RES;
                            res_ready <= 1'b1;
                        end else begin
                            c_cnt <= '0;
                            if (!r_last) begin
                                r_cnt <= r_cnt + 1'b1;
                                state <= ST_IFMAP;
                            end else begin
                                r_cnt <= '0;
                                if (!t_last) begin
                                    t_cnt <= t_cnt + 1'b1;
                                    state <= ST_IFMAP;
                                end else begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_snn_layer_scheduler.sv
// ============================================================================
// Module      : tb_snn_layer_scheduler
// Description : Scoreboard bench for snn_layer_scheduler with NUM_T=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snn_layer_scheduler;

    localparam int NT = 2;
    localparam int OD = 3;
    localparam int FS = 5;
    localparam int PC = 3;
    localparam int DW = 8;

    typedef logic [34:0] cmdw_t;   // {op, t, x, y, data}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
`ifdef SNN_SCHED_TIMEOUT_EN
    logic          error;
`endif
    logic          cmd_valid;
    logic          cmd_ready = 1'b1;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_t;
    logic [7:0]    cmd_x;
    logic [7:0]    cmd_y;
    logic [DW:0]   cmd_data;
    logic [PC-1:0] pe_start;
    logic [PC-1:0] pe_done = '0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [DW-1:0] res_membrane = '0;
    logic          res_spike = 1'b0;

    cmdw_t exp_q[$];
    cmdw_t mon_got;
    cmdw_t mon_exp;
    cmdw_t held;
    int    errors = 0;
    int    checks = 0;
    int    done_cnt = 0;
    int    cmd_cnt = 0;
    int    pe_mode = 0;
    int    d0;
    int    c0;

    always #5 clk = ~clk;

    snn_layer_scheduler #(
        .NUM_T        (NT),
        .OUT_DIM      (OD),
        .FILTER_SIZE  (FS),
        .PE_COUNT     (PC),
        .DATA_W       (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
`ifdef SNN_SCHED_TIMEOUT_EN
        .error        (error),
`endif
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_t        (cmd_t),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_data     (cmd_data),
        .pe_start     (pe_start),
        .pe_done      (pe_done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_membrane (res_membrane),
        .res_spike    (res_spike)
    );

    // Adder result presented for output pixel (t, r, c)
    function automatic logic [8:0] res_val(input int t, input int r, input int c);
        logic [7:0] m;
        logic       s;
        if (t == 1 && r == 2 && c == 1) return 9'h13C;
        m = 8'(t * 32 + r * 5 + c);
        s = ((c % 2) == 1);
        return {s, m};
    endfunction

    function automatic cmdw_t mk(input int op, input int t, input int x, input int y,
                                 input logic [8:0] d);
        return {2'(op), 8'(t), 8'(x), 8'(y), d};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected command stream for one complete run
    task automatic push_run();
        for (int i = 0; i < FS; i++) exp_q.push_back(mk(0, 0, i, 0, 9'h0));
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < OD; r++) begin
                for (int i = 0; i < FS; i++) exp_q.push_back(mk(1, t, r + i, 0, 9'h0));
                for (int c = 0; c < OD; c++) exp_q.push_back(mk(2, t, r, c, res_val(t, r, c)));
            end
    endtask

    task automatic run_start();
        push_run();
        @(posedge clk); #3;
        start = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (n < 3000 && !done) begin
            @(posedge clk); #3;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got done=0 expected done=1", name);
        end
        @(posedge clk); #3;
        check({name, "_done_one_cycle"}, done, 0);
        check({name, "_busy_low"}, busy, 0);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_cmd_count"}, cmd_cnt - c0, 53);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_cmd_valid"}, cmd_valid, 0);
        check({name, "_cmd_op"}, cmd_op, 0);
        check({name, "_cmd_t"}, cmd_t, 0);
        check({name, "_cmd_x"}, cmd_x, 0);
        check({name, "_cmd_y"}, cmd_y, 0);
        check({name, "_cmd_data"}, cmd_data, 0);
        check({name, "_pe_start"}, pe_start, 0);
        check({name, "_res_ready"}, res_ready, 0);
    endtask

    // Monitor: every accepted command is popped against the scoreboard
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && cmd_valid && cmd_ready) begin
            mon_got = {cmd_op, cmd_t, cmd_x, cmd_y, cmd_data};
            cmd_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got %h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL cmd_seq: got %h expected %h", mon_got, mon_exp);
                end
            end
            if (cmd_op == 2'b10 && cmd_t == 8'd1 && cmd_x == 8'd2 && cmd_y == 8'd1)
                check("wr_t1_r2_c1_data", cmd_data, 9'h13C);
        end
    end

    // PE and adder responder
    int   pe_cnt = -1;
    int   res_cnt = 0;
    int   mt = 0, mr = 0, mc = 0;
    logic stagger_now = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #2;
            pe_done = '0;
            if (!rst_n || !busy) begin
                pe_cnt = -1; res_cnt = 0; res_valid = 1'b0;
                mt = 0; mr = 0; mc = 0;
            end else begin
                if (pe_cnt >= 0) pe_cnt++;
                if (pe_cnt > 12) pe_cnt = -1;
                if (pe_start == '1) begin
                    pe_cnt = 0;
                    stagger_now = (pe_mode == 1);
                    pe_mode = 0;
                end
                if (stagger_now) begin
                    if (pe_cnt == 0) pe_done = 3'b001;
                    if (pe_cnt == 5) pe_done = 3'b100;
                    if (pe_cnt == 9) begin
                        pe_done = 3'b010;
                        check("stagger_wait_before_pe1", res_ready, 0);
                    end
                    if (pe_cnt == 10) begin
                        check("stagger_res_ready_after_pe1", res_ready, 1);
                        stagger_now = 1'b0;
                    end
                end else if (pe_cnt == 3) begin
                    pe_done = '1;
                end
                if (res_valid) begin
                    res_valid = 1'b0;
                    res_cnt = 0;
                    mc++;
                    if (mc == OD) begin
                        mc = 0; mr++;
                        if (mr == OD) begin mr = 0; mt++; end
                    end
                end else if (res_ready) begin
                    res_cnt++;
                    if (res_cnt == 3) begin
                        res_valid = 1'b1;
                        {res_spike, res_membrane} = res_val(mt, mr, mc);
                    end
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #3;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Plain run
        d0 = done_cnt; c0 = cmd_cnt;
        run_start();
        wait_done("run_a");

        // Staggered PE completion plus a 10-cycle stall inside IFMAP
        pe_mode = 1;
        d0 = done_cnt; c0 = cmd_cnt;
        run_start();
        n = 0;
        while (n < 500 && !(cmd_valid && cmd_op == 2'b01 && cmd_x == 8'd2)) begin
            @(posedge clk); #3;
            n++;
        end
        check("stall_target_found", (cmd_valid && cmd_op == 2'b01 && cmd_x == 8'd2), 1);
        cmd_ready = 1'b0;
        held = {cmd_op, cmd_t, cmd_x, cmd_y, cmd_data};
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #3;
            check("stall_valid_high", cmd_valid, 1);
            checks++;
            if ({cmd_op, cmd_t, cmd_x, cmd_y, cmd_data} !== held) begin
                errors++;
                $display("FAIL stall_payload: got %h expected %h",
                         {cmd_op, cmd_t, cmd_x, cmd_y, cmd_data}, held);
            end
        end
        cmd_ready = 1'b1;
        wait_done("run_b");

        // Ignored start, then reset while a write is pending
        run_start();
        repeat (2) @(posedge clk);
        #3;
        start = 1'b1;
        @(posedge clk); #3;
        start = 1'b0;
        n = 0;
        while (n < 500 && !res_valid) begin
            @(posedge clk); #3;
            n++;
        end
        cmd_ready = 1'b0;
        @(posedge clk); #3;
        check("midwrite_valid", cmd_valid, 1);
        check("midwrite_op", cmd_op, 2);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        d0 = done_cnt; c0 = cmd_cnt;
        run_start();
        wait_done("run_c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
